// File: rtl/inst_fetcher_pkg.sv
// ---------------------------------------------------------------------------
// inst_fetcher_pkg
//   Shared core constants and types for the instruction-fetch front end.
//   - INST_W / ADDR_W   : instruction word and address widths
//   - OPCODE_JAL        : RV32 JAL major opcode
//   - fetch_state_e     : fetch FSM state encodings
//   - fq_entry_t        : one fetch-queue entry {pc, instruction}
// ---------------------------------------------------------------------------
package inst_fetcher_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [6:0] OPCODE_JAL = 7'b1101111;

  typedef enum logic [1:0] {
    FS_IDLE    = 2'd0,
    FS_REQ     = 2'd1,
    FS_WAIT    = 2'd2,
    FS_DISCARD = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [INST_W-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//   Circular FIFO of fetched {pc, instruction} entries.
//   Ports:
//     clk_in, rst_in_n : clock, asynchronous active-low reset
//     en               : global advance enable; nothing changes while low
//     flush            : clear the queue; wins over push and pop
//     push, push_entry : enqueue one entry (ignored when full)
//     pop              : dequeue the head (ignored when empty)
//     head_valid       : queue not empty
//     head_entry       : head entry; holds the last head value while empty
//     count            : number of valid entries (0..FQ_DEPTH)
// ---------------------------------------------------------------------------
module fetch_queue
  import inst_fetcher_pkg::*;
#(
  parameter int FQ_DEPTH = 4,
  localparam int PTR_W = $clog2(FQ_DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_in,
  input  logic             rst_in_n,
  input  logic             en,
  input  logic             flush,
  input  logic             push,
  input  fq_entry_t        push_entry,
  input  logic             pop,
  output logic             head_valid,
  output fq_entry_t        head_entry,
  output logic [CNT_W-1:0] count
);

  fq_entry_t        mem [FQ_DEPTH];
  fq_entry_t        hold_entry;
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign head_valid = (count != '0);
  assign full       = (count == CNT_W'(FQ_DEPTH));
  assign do_push    = en && !flush && push && !full;
  assign do_pop     = en && !flush && pop && head_valid;

  // While empty the decoder still sees the most recent head, not a stale slot.
  assign head_entry = head_valid ? mem[head_ptr] : hold_entry;

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      head_ptr   <= '0;
      tail_ptr   <= '0;
      count      <= '0;
      hold_entry <= '0;
    end else if (en) begin
      if (head_valid) begin
        hold_entry <= mem[head_ptr];
      end
      if (flush) begin
        head_ptr <= '0;
        tail_ptr <= '0;
        count    <= '0;
      end else begin
        if (do_push) begin
          tail_ptr <= tail_ptr + PTR_W'(1);
        end
        if (do_pop) begin
          head_ptr <= head_ptr + PTR_W'(1);
        end
        case ({do_push, do_pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage is pure data: written only on an accepted push, never reset.
  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem[tail_ptr] <= push_entry;
    end
  end

endmodule

// File: rtl/inst_fetcher.sv
// ---------------------------------------------------------------------------
// inst_fetcher
//   Instruction-fetch front end. Walks sequential PCs, issues one outstanding
//   word read at a time, buffers returned words with their PCs in a fetch
//   queue and presents the queue head to the decoder. A redirect flushes the
//   queue and restarts fetch; an in-flight read is then drained and dropped.
//
//   Optional build macro FETCH_JAL_PREDICT_EN: a returned JAL steers the next
//   fetch to its target instead of pc+4.
//
//   Ports:
//     clk_in, rst_in_n        : clock, asynchronous active-low reset
//     rdy_in                  : global pause, all state holds while low
//     mem_req_valid/addr      : fetch request toward the memory controller
//     mem_req_ready           : controller accepts the request this cycle
//     mem_resp_valid/data     : one-cycle fetch response
//     dec_valid/inst_addr/inst: queue head toward the decoder
//     dec_stall               : decoder cannot accept this cycle
//     redirect_valid/pc       : flush and restart at redirect_pc (word-aligned)
// ---------------------------------------------------------------------------
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0,
  parameter int                FQ_DEPTH = 4
) (
  input  logic              clk_in,
  input  logic              rst_in_n,
  input  logic              rdy_in,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [INST_W-1:0] mem_resp_data,
  output logic              dec_valid,
  output logic [ADDR_W-1:0] dec_inst_addr,
  output logic [INST_W-1:0] dec_inst,
  input  logic              dec_stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

  fetch_state_e      state_q;
  fetch_state_e      state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] next_pc;
  logic              load_fetch_pc;

  logic              fq_head_valid;
  fq_entry_t         fq_head;
  fq_entry_t         fq_push_entry;
  logic [CNT_W-1:0]  fq_count;
  logic [CNT_W-1:0]  count_after;
  logic              pop;
  logic              resp_take;

`ifdef FETCH_JAL_PREDICT_EN
  function automatic logic signed [ADDR_W-1:0] jal_offset(input logic [INST_W-1:0] inst);
    logic signed [20:0] imm;
    imm = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    return ADDR_W'(imm);
  endfunction

  logic signed [ADDR_W-1:0] jal_imm;
  assign jal_imm = jal_offset(mem_resp_data);
  assign next_pc = (mem_resp_data[6:0] == OPCODE_JAL) ? fetch_pc_q + $unsigned(jal_imm)
                                                      : fetch_pc_q + ADDR_W'(4);
`else
  assign next_pc = fetch_pc_q + ADDR_W'(4);
`endif

  // The request is withdrawn during reset and in a redirect cycle so a stale
  // address is never handed to the controller.
  assign mem_req_valid = rst_in_n && (state_q == FS_REQ) && !redirect_valid;
  assign mem_req_addr  = pc_q;

  assign dec_valid     = fq_head_valid;
  assign dec_inst_addr = fq_head.addr;
  assign dec_inst      = fq_head.inst;

  assign pop       = fq_head_valid && !dec_stall && rdy_in && !redirect_valid;
  assign resp_take = (state_q == FS_WAIT) && mem_resp_valid && rdy_in && !redirect_valid;

  assign fq_push_entry = '{addr: fetch_pc_q, inst: mem_resp_data};

  // Occupancy once this cycle's push/pop land; decides whether another word
  // may be requested (each request reserves one slot).
  assign count_after = fq_count + CNT_W'(resp_take) - CNT_W'(pop);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    load_fetch_pc = 1'b0;
    if (redirect_valid) begin
      pc_d = redirect_pc & ~ADDR_W'(3);
      case (state_q)
        // An outstanding read must still be drained unless it returns now.
        FS_WAIT, FS_DISCARD: state_d = mem_resp_valid ? FS_REQ : FS_DISCARD;
        default:             state_d = FS_REQ;
      endcase
    end else begin
      case (state_q)
        FS_IDLE: begin
          if (fq_count < CNT_W'(FQ_DEPTH)) begin
            state_d = FS_REQ;
          end
        end
        FS_REQ: begin
          if (mem_req_ready) begin
            state_d       = FS_WAIT;
            load_fetch_pc = 1'b1;
          end
        end
        FS_WAIT: begin
          if (mem_resp_valid) begin
            pc_d    = next_pc;
            state_d = (count_after < CNT_W'(FQ_DEPTH)) ? FS_REQ : FS_IDLE;
          end
        end
        FS_DISCARD: begin
          if (mem_resp_valid) begin
            state_d = FS_REQ;
          end
        end
        default: state_d = FS_REQ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q <= FS_REQ;
      pc_q    <= RESET_PC;
    end else if (rdy_in) begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // PC of the in-flight read; only meaningful while in WAIT.
  always_ff @(posedge clk_in) begin
    if (rdy_in && load_fetch_pc) begin
      fetch_pc_q <= pc_q;
    end
  end

  fetch_queue #(
    .FQ_DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk_in     (clk_in),
    .rst_in_n   (rst_in_n),
    .en         (rdy_in),
    .flush      (redirect_valid),
    .push       (resp_take),
    .push_entry (fq_push_entry),
    .pop        (pop),
    .head_valid (fq_head_valid),
    .head_entry (fq_head),
    .count      (fq_count)
  );

endmodule

// File: tb/tb_inst_fetcher.sv
module tb_inst_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in_n;
  logic        rdy_in;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        dec_valid;
  logic [31:0] dec_inst_addr;
  logic [31:0] dec_inst;
  logic        dec_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_cmp = 0;
  int n_bad = 0;

  // memory controller model state
  bit          seen;
  int          cnt;
  int          lat;
  bit          force_dead;
  logic [31:0] resp_addr;
  logic        samp_valid;
  logic        samp_ready;
  logic [31:0] samp_addr;

  typedef struct {
    bit          rst;
    logic        stall;
    logic        rv;
    logic [31:0] ra;
    logic        dv;
    logic [31:0] da;
  } vec_t;
  vec_t tab[$];

  always #5 clk_in = ~clk_in;

  inst_fetcher #(
    .RESET_PC (32'h0),
    .FQ_DEPTH (4)
  ) dut (
    .clk_in         (clk_in),
    .rst_in_n       (rst_in_n),
    .rdy_in         (rdy_in),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .dec_valid      (dec_valid),
    .dec_inst_addr  (dec_inst_addr),
    .dec_inst       (dec_inst),
    .dec_stall      (dec_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h20) return 32'h0100006F;
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs; the controller answers from its own state.
  task automatic setup(input logic stall, input logic redir, input logic [31:0] rpc);
    dec_stall      = stall;
    redirect_valid = redir;
    redirect_pc    = rpc;
    mem_resp_valid = rdy_in && (cnt == 1);
    mem_resp_data  = force_dead ? 32'hDEADBEEF : mem_word(resp_addr);
    #1;
    // accepts a request the cycle after it first appears; while paused it
    // offers ready to prove the fetcher ignores it
    mem_req_ready = mem_req_valid && (seen || !rdy_in);
    #1;
    samp_valid = mem_req_valid;
    samp_ready = mem_req_ready;
    samp_addr  = mem_req_addr;
  endtask

  task automatic advance();
    @(posedge clk_in);
    if (rdy_in) begin
      if (samp_valid && samp_ready) begin
        cnt       = lat;
        resp_addr = samp_addr;
      end else if (cnt > 0) begin
        cnt--;
      end
      seen = samp_valid && !samp_ready;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_in_n       = 1'b0;
    rdy_in         = 1'b1;
    dec_stall      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    seen = 0; cnt = 0; lat = 1; force_dead = 0; resp_addr = '0;
    @(posedge clk_in);
    #1;
    chk1("rst req_valid", mem_req_valid, 1'b0);
    chk("rst req_addr", mem_req_addr, 32'h0);
    chk1("rst dec_valid", dec_valid, 1'b0);
    chk("rst dec_inst_addr", dec_inst_addr, 32'h0);
    chk("rst dec_inst", dec_inst, 32'h0);
    rst_in_n = 1'b1;
  endtask

  task automatic add(input bit r, input logic s, input logic rv, input logic [31:0] ra,
                     input logic dv, input logic [31:0] da);
    vec_t v;
    v.rst = r; v.stall = s; v.rv = rv; v.ra = ra; v.dv = dv; v.da = da;
    tab.push_back(v);
  endtask

  task automatic redir_fetch(input string tag, input logic [31:0] rpc, input logic [31:0] nxt);
    do_reset();
    setup(0, 1, rpc);
    chk1({tag, " redir req_valid"}, mem_req_valid, 1'b0);
    advance();
    setup(0, 0, 0);
    chk1({tag, " req_valid"}, mem_req_valid, 1'b1);
    chk({tag, " req_addr"}, mem_req_addr, rpc);
    advance();
    setup(0, 0, 0); advance();
    setup(0, 0, 0); advance();
    setup(0, 0, 0);
    chk1({tag, " dec_valid"}, dec_valid, 1'b1);
    chk({tag, " dec_inst_addr"}, dec_inst_addr, rpc);
    chk({tag, " dec_inst"}, dec_inst, mem_word(rpc));
    chk1({tag, " next req_valid"}, mem_req_valid, 1'b1);
    chk({tag, " next req_addr"}, mem_req_addr, nxt);
    advance();
  endtask

  initial begin
    // streaming run, no stall: one word every 3 cycles
    add(1, 0, 1, 32'h0, 0, 0);
    add(0, 0, 1, 32'h0, 0, 0);
    add(0, 0, 0, 32'h0, 0, 0);
    add(0, 0, 1, 32'h4, 1, 32'h0);
    add(0, 0, 1, 32'h4, 0, 0);
    add(0, 0, 0, 32'h4, 0, 0);
    add(0, 0, 1, 32'h8, 1, 32'h4);
    add(0, 0, 1, 32'h8, 0, 0);
    add(0, 0, 0, 32'h8, 0, 0);
    add(0, 0, 1, 32'hC, 1, 32'h8);
    // decoder stalled: queue fills to 4 then fetch idles; release drains
    add(1, 1, 1, 32'h0, 0, 0);
    add(0, 1, 1, 32'h0, 0, 0);
    add(0, 1, 0, 32'h0, 0, 0);
    add(0, 1, 1, 32'h4, 1, 32'h0);
    add(0, 1, 1, 32'h4, 1, 32'h0);
    add(0, 1, 0, 32'h4, 1, 32'h0);
    add(0, 1, 1, 32'h8, 1, 32'h0);
    add(0, 1, 1, 32'h8, 1, 32'h0);
    add(0, 1, 0, 32'h8, 1, 32'h0);
    add(0, 1, 1, 32'hC, 1, 32'h0);
    add(0, 1, 1, 32'hC, 1, 32'h0);
    add(0, 1, 0, 32'hC, 1, 32'h0);
    add(0, 1, 0, 32'h10, 1, 32'h0);
    add(0, 1, 0, 32'h10, 1, 32'h0);
    add(0, 0, 0, 32'h10, 1, 32'h0);
    add(0, 0, 0, 32'h10, 1, 32'h4);
    add(0, 0, 1, 32'h10, 1, 32'h8);
    add(0, 0, 1, 32'h10, 1, 32'hC);
    add(0, 0, 0, 32'h10, 0, 0);
    add(0, 0, 1, 32'h14, 1, 32'h10);

    for (int i = 0; i < tab.size(); i++) begin
      if (tab[i].rst) do_reset();
      setup(tab[i].stall, 0, 0);
      chk1($sformatf("vec%0d req_valid", i), mem_req_valid, tab[i].rv);
      chk($sformatf("vec%0d req_addr", i), mem_req_addr, tab[i].ra);
      chk1($sformatf("vec%0d dec_valid", i), dec_valid, tab[i].dv);
      if (tab[i].dv) begin
        chk($sformatf("vec%0d dec_inst_addr", i), dec_inst_addr, tab[i].da);
        chk($sformatf("vec%0d dec_inst", i), dec_inst, mem_word(tab[i].da));
      end
      advance();
    end

    // redirect while a slow read is outstanding: its data must be dropped
    do_reset();
    lat = 3;
    setup(0, 0, 0); advance();
    setup(0, 0, 0);
    chk1("wredir accept valid", mem_req_valid, 1'b1);
    advance();
    setup(0, 1, 32'h103);
    chk1("wredir req_valid", mem_req_valid, 1'b0);
    advance();
    setup(0, 0, 0);
    chk1("wredir discard req_valid", mem_req_valid, 1'b0);
    chk("wredir pc", mem_req_addr, 32'h100);
    chk1("wredir discard dec_valid", dec_valid, 1'b0);
    advance();
    force_dead = 1;
    lat = 1;
    setup(0, 0, 0);
    chk1("wredir stale resp dec_valid", dec_valid, 1'b0);
    advance();
    force_dead = 0;
    setup(0, 0, 0);
    chk1("wredir restart req_valid", mem_req_valid, 1'b1);
    chk("wredir restart req_addr", mem_req_addr, 32'h100);
    chk1("wredir dropped dec_valid", dec_valid, 1'b0);
    advance();
    setup(0, 0, 0); advance();
    setup(0, 0, 0);
    chk1("wredir wait dec_valid", dec_valid, 1'b0);
    advance();
    setup(0, 0, 0);
    chk1("wredir first dec_valid", dec_valid, 1'b1);
    chk("wredir first dec_inst_addr", dec_inst_addr, 32'h100);
    advance();

    // redirect coinciding with a response and a pop
    do_reset();
    for (int c = 0; c < 5; c++) begin
      setup(1, 0, 0); advance();
    end
    setup(0, 1, 32'h200);
    chk1("coll resp present", mem_resp_valid, 1'b1);
    chk1("coll dec_valid", dec_valid, 1'b1);
    chk("coll dec_inst_addr", dec_inst_addr, 32'h0);
    chk1("coll req_valid", mem_req_valid, 1'b0);
    advance();
    setup(0, 0, 0);
    chk1("coll flushed dec_valid", dec_valid, 1'b0);
    chk("coll hold dec_inst_addr", dec_inst_addr, 32'h0);
    chk1("coll req_valid", mem_req_valid, 1'b1);
    chk("coll req_addr", mem_req_addr, 32'h200);
    advance();
    setup(0, 0, 0);
    chk1("coll dropped dec_valid a", dec_valid, 1'b0);
    advance();
    setup(0, 0, 0);
    chk1("coll dropped dec_valid b", dec_valid, 1'b0);
    advance();
    setup(0, 0, 0);
    chk1("coll first dec_valid", dec_valid, 1'b1);
    chk("coll first dec_inst_addr", dec_inst_addr, 32'h200);
    advance();

    // global pause mid-stream, with ready offered during the pause
    do_reset();
    for (int c = 0; c < 3; c++) begin
      setup(0, 0, 0); advance();
    end
    rdy_in = 1'b0;
    for (int c = 0; c < 5; c++) begin
      setup(0, 0, 0);
      chk1($sformatf("pause%0d req_valid", c), mem_req_valid, 1'b1);
      chk($sformatf("pause%0d req_addr", c), mem_req_addr, 32'h4);
      chk1($sformatf("pause%0d dec_valid", c), dec_valid, 1'b1);
      chk($sformatf("pause%0d dec_inst_addr", c), dec_inst_addr, 32'h0);
      chk($sformatf("pause%0d dec_inst", c), dec_inst, mem_word(32'h0));
      advance();
    end
    rdy_in = 1'b1;
    setup(0, 0, 0);
    chk1("resume dec_valid", dec_valid, 1'b1);
    chk("resume dec_inst_addr", dec_inst_addr, 32'h0);
    chk("resume req_addr", mem_req_addr, 32'h4);
    advance();
    setup(0, 0, 0);
    chk1("resume popped dec_valid", dec_valid, 1'b0);
    chk1("resume accept req_valid", mem_req_valid, 1'b1);
    advance();
    setup(0, 0, 0);
    chk1("resume wait req_valid", mem_req_valid, 1'b0);
    advance();
    setup(0, 0, 0);
    chk1("resume next dec_valid", dec_valid, 1'b1);
    chk("resume next dec_inst_addr", dec_inst_addr, 32'h4);
    chk("resume next req_addr", mem_req_addr, 32'h8);
    advance();

    // JAL at 0x20 (jal x0,+16) and pc wrap at the top of the address space
`ifdef FETCH_JAL_PREDICT_EN
    redir_fetch("jal", 32'h20, 32'h30);
`else
    redir_fetch("jal", 32'h20, 32'h24);
`endif
    redir_fetch("wrap", 32'hFFFF_FFFC, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
